// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS core: fetch FSM states, Branch bit indices
// and instruction field positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        FETCH      = 2'd1,
        HOLD       = 2'd2
    } fetch_state_t;

    // Bit positions within the decoder's Branch vector
    localparam int BR_BEQ = 0;
    localparam int BR_BNE = 1;

    // Instruction field positions
    localparam int OP_MSB     = 31;
    localparam int OP_LSB     = 26;
    localparam int FUNC_MSB   = 5;
    localparam int FUNC_LSB   = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int TARGET_MSB = 25;
    localparam int TARGET_LSB = 0;

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: jump beats a taken branch, which beats the sequential step.
// All arithmetic is modulo 2^32; every form yields a word-aligned address.
module npc_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] npc
);

    logic [31:0] pc4;
    logic [31:0] brOffset;
    logic [31:0] brTarget;
    logic [31:0] jTarget;
    logic        taken;
    logic        unusedOp;

    assign pc4      = pc + 32'd4;
    assign brOffset = {{14{instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB], 2'b00};
    assign brTarget = pc4 + brOffset;
    assign jTarget  = {pc4[31:28], instr[TARGET_MSB:TARGET_LSB], 2'b00};
    // Branch=2'b11 is taken whatever Zero is, by construction of this formula
    assign taken    = (Branch[BR_BEQ] & Zero) | (Branch[BR_BNE] & ~Zero);
    // Opcode bits are decoded upstream and not needed here
    assign unusedOp = ^instr[OP_MSB:OP_LSB];

    // Select next PC by priority
    always_comb begin
        npc = pc4;
        if (Jump) begin
            npc = jTarget;
        end else if (taken) begin
            npc = brTarget;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch and PC sequencing: one req/ack fetch, hold the word until
// the datapath commits it, then step the PC to the computed next address.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Func,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        commit,
    input  logic [1:0]  Branch,
    input  logic        Jump,
    input  logic        Zero
);

    fetch_state_t stateQ;
    fetch_state_t stateD;
    logic [31:0]  pcQ;
    logic [31:0]  instrQ;
    logic [31:0]  npc;

    npc_calc uNpcCalc (
        .pc     (pcQ),
        .instr  (instrQ),
        .Branch (Branch),
        .Jump   (Jump),
        .Zero   (Zero),
        .npc    (npc)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= RESET_WAIT;
        end else begin
            stateQ <= stateD;
        end
    end

    // Next-state logic; ack outside FETCH and commit outside HOLD are ignored
    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            RESET_WAIT: stateD = FETCH;
            FETCH:      if (imem_ack) stateD = HOLD;
            HOLD:       if (commit) stateD = FETCH;
            default:    stateD = RESET_WAIT;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        unique case (stateQ)
            FETCH:   imem_req = 1'b1;
            HOLD:    instr_valid = 1'b1;
            default: ;
        endcase
    end

    // PC and instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcQ    <= RESET_PC;
            instrQ <= 32'h0;
        end else begin
            if (stateQ == FETCH && imem_ack) begin
                instrQ <= imem_rdata;
            end
            if (stateQ == HOLD && commit) begin
                pcQ <= npc;
            end
        end
    end

    assign imem_addr = pcQ;
    assign pc        = pcQ;
    assign instr     = instrQ;
    assign OP        = instrQ[OP_MSB:OP_LSB];
    assign Func      = instrQ[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imemReq, imemAck, instrValid, commit, jump, zero;
    logic [31:0] imemAddr, imemRdata, instr, pc;
    logic [5:0]  op, func;
    logic [1:0]  branch;

    logic        req2, ack2, valid2, commit2, jump2, zero2;
    logic [31:0] addr2, rdata2, instr2, pc2;
    logic [5:0]  op2, func2;
    logic [1:0]  branch2;

    int total = 0;
    int bad = 0;

    fetch_unit #(.RESET_PC(32'h0000_0040)) uDut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imemReq),
        .imem_addr   (imemAddr),
        .imem_ack    (imemAck),
        .imem_rdata  (imemRdata),
        .instr       (instr),
        .OP          (op),
        .Func        (func),
        .instr_valid (instrValid),
        .pc          (pc),
        .commit      (commit),
        .Branch      (branch),
        .Jump        (jump),
        .Zero        (zero)
    );

    // Second instance parked in the upper address region for the jump case
    fetch_unit #(.RESET_PC(32'h8000_0010)) uDutHi (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (req2),
        .imem_addr   (addr2),
        .imem_ack    (ack2),
        .imem_rdata  (rdata2),
        .instr       (instr2),
        .OP          (op2),
        .Func        (func2),
        .instr_valid (valid2),
        .pc          (pc2),
        .commit      (commit2),
        .Branch      (branch2),
        .Jump        (jump2),
        .Zero        (zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchAck(input logic [31:0] word);
        imemAck = 1'b1;
        imemRdata = word;
        tick();
        imemAck = 1'b0;
    endtask

    task automatic doCommit(input logic [1:0] br, input logic j, input logic z);
        branch = br;
        jump = j;
        zero = z;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        branch = 2'b00;
        jump = 1'b0;
        zero = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imemReq !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", imemReq); end
        total++; if (instrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", instrValid); end
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL reset_pc got %h want 00000040", pc); end
        total++; if (instr !== 32'h0 || op !== 6'h0 || func !== 6'h0) begin
            bad++; $display("FAIL reset_instr got %h/%h/%h want 0", instr, op, func);
        end
        total++; if (pc2 !== 32'h8000_0010) begin bad++; $display("FAIL reset_pc_hi got %h want 80000010", pc2); end
    endtask

    task automatic test_first_fetch();
        rst_n = 1'b1;
        tick();
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
            bad++; $display("FAIL first_req got req=%b addr=%h want 1/00000040", imemReq, imemAddr);
        end
        tick();
        tick();
        total++; if (imemReq !== 1'b1 || instrValid !== 1'b0) begin
            bad++; $display("FAIL wait_req got req=%b valid=%b want 1/0", imemReq, instrValid);
        end
        fetchAck(32'h2008_0005);
        total++; if (instrValid !== 1'b1 || imemReq !== 1'b0) begin
            bad++; $display("FAIL ack_hs got valid=%b req=%b want 1/0", instrValid, imemReq);
        end
        total++; if (op !== 6'b001000 || func !== 6'b000101 || instr !== 32'h2008_0005) begin
            bad++; $display("FAIL ack_fields got op=%b func=%b instr=%h want 001000/000101/20080005", op, func, instr);
        end
    endtask

    task automatic test_sequential();
        doCommit(2'b00, 1'b0, 1'b0);
        total++; if (imemAddr !== 32'h44 || imemReq !== 1'b1 || instrValid !== 1'b0) begin
            bad++; $display("FAIL seq got addr=%h req=%b valid=%b want 00000044/1/0", imemAddr, imemReq, instrValid);
        end
        // j to target 0x40 -> 0x100
        fetchAck(32'h0800_0040);
        doCommit(2'b00, 1'b1, 1'b0);
        total++; if (imemAddr !== 32'h100) begin bad++; $display("FAIL jump_low got %h want 00000100", imemAddr); end
    endtask

    task automatic test_beq();
        fetchAck(32'h1000_FFFE);
        doCommit(2'b01, 1'b0, 1'b1);
        total++; if (imemAddr !== 32'h0FC) begin bad++; $display("FAIL beq_taken got %h want 000000fc", imemAddr); end
        // beq +0 taken from 0xFC returns to 0x100
        fetchAck(32'h1000_0000);
        doCommit(2'b01, 1'b0, 1'b1);
        total++; if (imemAddr !== 32'h100) begin bad++; $display("FAIL beq_zero_off got %h want 00000100", imemAddr); end
        fetchAck(32'h1000_FFFE);
        doCommit(2'b01, 1'b0, 1'b0);
        total++; if (imemAddr !== 32'h104) begin bad++; $display("FAIL beq_not_taken got %h want 00000104", imemAddr); end
    endtask

    task automatic test_bne_jump();
        // j target 0x80 -> 0x200
        fetchAck(32'h0800_0080);
        doCommit(2'b00, 1'b1, 1'b0);
        total++; if (imemAddr !== 32'h200) begin bad++; $display("FAIL jump_200 got %h want 00000200", imemAddr); end
        fetchAck(32'h1400_0003);
        doCommit(2'b10, 1'b0, 1'b0);
        total++; if (imemAddr !== 32'h210) begin bad++; $display("FAIL bne_taken got %h want 00000210", imemAddr); end
        // Jump wins over a taken beq in the upper region
        ack2 = 1'b1;
        rdata2 = 32'h0800_0040;
        tick();
        ack2 = 1'b0;
        branch2 = 2'b01;
        zero2 = 1'b1;
        jump2 = 1'b1;
        commit2 = 1'b1;
        tick();
        commit2 = 1'b0;
        total++; if (addr2 !== 32'h8000_0100 || req2 !== 1'b1) begin
            bad++; $display("FAIL jump_wins got addr=%h req=%b want 80000100/1", addr2, req2);
        end
    endtask

    task automatic test_wrap();
        // Negative offset from 0x210: 0x214 - 0x218 = 0xFFFFFFFC
        fetchAck(32'h1000_FF7A);
        doCommit(2'b01, 1'b0, 1'b1);
        total++; if (imemAddr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL neg_wrap got %h want fffffffc", imemAddr); end
        fetchAck(32'h0000_0020);
        doCommit(2'b00, 1'b0, 1'b0);
        total++; if (imemAddr !== 32'h0) begin bad++; $display("FAIL seq_wrap got %h want 00000000", imemAddr); end
    endtask

    task automatic test_protocol();
        // commit while in FETCH is ignored
        jump = 1'b1;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        jump = 1'b0;
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h0 || instrValid !== 1'b0) begin
            bad++; $display("FAIL commit_in_fetch got req=%b addr=%h valid=%b want 1/00000000/0", imemReq, imemAddr, instrValid);
        end
        fetchAck(32'h0000_002A);
        tick();
        total++; if (instrValid !== 1'b1 || pc !== 32'h0 || instr !== 32'h2A) begin
            bad++; $display("FAIL hold_stable got valid=%b pc=%h instr=%h want 1/00000000/0000002a", instrValid, pc, instr);
        end
        // stray ack while in HOLD is ignored
        fetchAck(32'hDEAD_BEEF);
        total++; if (instr !== 32'h2A || instrValid !== 1'b1 || imemReq !== 1'b0 || pc !== 32'h0) begin
            bad++; $display("FAIL ack_in_hold got instr=%h valid=%b req=%b pc=%h want 0000002a/1/0/00000000", instr, instrValid, imemReq, pc);
        end
    endtask

    task automatic test_async_reset();
        doCommit(2'b00, 1'b0, 1'b0);
        total++; if (imemAddr !== 32'h4 || imemReq !== 1'b1) begin
            bad++; $display("FAIL pre_reset got addr=%h req=%b want 00000004/1", imemAddr, imemReq);
        end
        #2;
        rst_n = 1'b0;
        #0.5;
        total++; if (imemReq !== 1'b0 || pc !== 32'h40 || instr !== 32'h0 || instrValid !== 1'b0) begin
            bad++; $display("FAIL async_reset got req=%b pc=%h instr=%h valid=%b want 0/00000040/0/0", imemReq, pc, instr, instrValid);
        end
        #0.5;
        rst_n = 1'b1;
        tick();
        total++; if (imemReq !== 1'b1 || imemAddr !== 32'h40) begin
            bad++; $display("FAIL post_reset got req=%b addr=%h want 1/00000040", imemReq, imemAddr);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imemAck = 1'b0;
        imemRdata = 32'h0;
        commit = 1'b0;
        branch = 2'b00;
        jump = 1'b0;
        zero = 1'b0;
        ack2 = 1'b0;
        rdata2 = 32'h0;
        commit2 = 1'b0;
        branch2 = 2'b00;
        jump2 = 1'b0;
        zero2 = 1'b0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_beq();
        test_bne_jump();
        test_wrap();
        test_protocol();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
